// File: rtl/param_sram_arbiter_if.sv
// Request/response and SRAM bus bundle for param_sram_arbiter.
// The slave modport is the arbiter; the master modport is the requesters plus the SRAM.
interface param_sram_arbiter_if #(
   parameter int AddressSize = 32,
   parameter int Bits        = 32
);
   logic                   p0_req;
   logic                   p0_we;
   logic [AddressSize-1:0] p0_addr;
   logic [Bits-1:0]        p0_wdata;
   logic                   p0_gnt;
   logic                   p0_rvalid;
   logic [Bits-1:0]        p0_rdata;

   logic                   p1_req;
   logic                   p1_we;
   logic [AddressSize-1:0] p1_addr;
   logic [Bits-1:0]        p1_wdata;
   logic                   p1_gnt;
   logic                   p1_rvalid;
   logic [Bits-1:0]        p1_rdata;

   logic                   mem_cs;
   logic                   mem_oe;
   logic                   mem_W_req;
   logic [AddressSize-1:0] mem_addr;
   logic [Bits-1:0]        mem_W_data;
   logic [Bits-1:0]        mem_R_data;

   modport slave (
      input  p0_req, p0_we, p0_addr, p0_wdata,
      input  p1_req, p1_we, p1_addr, p1_wdata,
      input  mem_R_data,
      output p0_gnt, p0_rvalid, p0_rdata,
      output p1_gnt, p1_rvalid, p1_rdata,
      output mem_cs, mem_oe, mem_W_req, mem_addr, mem_W_data
   );

   modport master (
      output p0_req, p0_we, p0_addr, p0_wdata,
      output p1_req, p1_we, p1_addr, p1_wdata,
      output mem_R_data,
      input  p0_gnt, p0_rvalid, p0_rdata,
      input  p1_gnt, p1_rvalid, p1_rdata,
      input  mem_cs, mem_oe, mem_W_req, mem_addr, mem_W_data
   );
endinterface

// File: rtl/param_sram_arbiter.sv
// Two-port arbiter/sequencer in front of the single-port parameter SRAM.
// Define PARAM_ARB_RR_EN for round-robin arbitration; otherwise port 0 has fixed priority.
module param_sram_arbiter #(
   parameter int AddressSize = 32,
   parameter int Bits        = 32,
   parameter int Words       = 4
) (
   input logic                   clk,
   input logic                   rst_n,
   param_sram_arbiter_if.slave   bus
);

   logic                   arb_en;
   logic                   gnt0;
   logic                   gnt1;
   logic                   any_gnt;
   logic                   win_we;
   logic [AddressSize-1:0] win_addr;
   logic [Bits-1:0]        win_wdata;
   logic                   win_in_range;
   logic                   rsp_valid_p1;
   logic                   rsp_port_p1;
   logic                   rsp_oor_p1;

   function automatic logic in_range(input logic [AddressSize-1:0] a);
      return a < AddressSize'(Words);
   endfunction

`ifdef PARAM_ARB_RR_EN
   logic prio;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    prio <= 1'b0;
      else if (gnt0) prio <= 1'b1;
      else if (gnt1) prio <= 1'b0;
   end
`endif

   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (arb_en) begin
`ifdef PARAM_ARB_RR_EN
         if (bus.p0_req && bus.p1_req) begin
            gnt0 = ~prio;
            gnt1 = prio;
         end else begin
            gnt0 = bus.p0_req;
            gnt1 = bus.p1_req;
         end
`else
         gnt0 = bus.p0_req;
         gnt1 = bus.p1_req & ~bus.p0_req;
`endif
      end
   end

   assign any_gnt      = gnt0 | gnt1;
   assign win_we       = gnt1 ? bus.p1_we    : bus.p0_we;
   assign win_addr     = gnt1 ? bus.p1_addr  : bus.p0_addr;
   assign win_wdata    = gnt1 ? bus.p1_wdata : bus.p0_wdata;
   assign win_in_range = in_range(win_addr);

   assign bus.p0_gnt     = gnt0;
   assign bus.p1_gnt     = gnt1;
   // Out-of-range accesses are granted but never reach the array.
   assign bus.mem_cs     = any_gnt & win_in_range;
   assign bus.mem_W_req  = any_gnt ? ~win_we  : 1'b1;
   assign bus.mem_addr   = any_gnt ? win_addr : '0;
   assign bus.mem_W_data = any_gnt ? win_wdata : '0;

   // Stage p1: read response, one cycle after the grant.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         arb_en       <= 1'b0;
         rsp_valid_p1 <= 1'b0;
         rsp_port_p1  <= 1'b0;
         rsp_oor_p1   <= 1'b0;
      end else begin
         arb_en       <= 1'b1;
         rsp_valid_p1 <= any_gnt & ~win_we;
         rsp_port_p1  <= gnt1;
         rsp_oor_p1   <= ~win_in_range;
      end
   end

   assign bus.mem_oe    = rsp_valid_p1 & ~rsp_oor_p1;
   assign bus.p0_rvalid = rsp_valid_p1 & ~rsp_port_p1;
   assign bus.p1_rvalid = rsp_valid_p1 &  rsp_port_p1;
   assign bus.p0_rdata  = (bus.p0_rvalid && !rsp_oor_p1) ? bus.mem_R_data : '0;
   assign bus.p1_rdata  = (bus.p1_rvalid && !rsp_oor_p1) ? bus.mem_R_data : '0;

endmodule

// File: tb/tb_param_sram_arbiter.sv
// Directed bench for param_sram_arbiter with a behavioural 4-word registered-read SRAM.
module tb_param_sram_arbiter;

   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_bad;

   logic [31:0] sram [4];
   logic [31:0] sram_q;

   param_sram_arbiter_if #(.AddressSize(32), .Bits(32)) bus ();

   param_sram_arbiter #(.AddressSize(32), .Bits(32), .Words(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // SRAM decodes only the low address bits, so a leaked out-of-range write would alias.
   always @(posedge clk) begin
      if (bus.mem_cs) begin
         if (!bus.mem_W_req) sram[bus.mem_addr[1:0]] <= bus.mem_W_data;
         else                sram_q <= sram[bus.mem_addr[1:0]];
      end
   end
   assign bus.mem_R_data = bus.mem_oe ? sram_q : 32'h0;

   task automatic drive_idle();
      bus.p0_req = 1'b0; bus.p0_we = 1'b0; bus.p0_addr = 32'h0; bus.p0_wdata = 32'h0;
      bus.p1_req = 1'b0; bus.p1_we = 1'b0; bus.p1_addr = 32'h0; bus.p1_wdata = 32'h0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      bus.p0_req = 1'b1; bus.p0_addr = 32'd0;
      bus.p1_req = 1'b1; bus.p1_addr = 32'd1;
      @(negedge clk); #1;
      n_cmp++; if (bus.p0_gnt !== 1'b0) begin n_bad++; $display("FAIL rst_p0_gnt got=%0b exp=0", bus.p0_gnt); end
      n_cmp++; if (bus.p1_gnt !== 1'b0) begin n_bad++; $display("FAIL rst_p1_gnt got=%0b exp=0", bus.p1_gnt); end
      n_cmp++; if (bus.mem_cs !== 1'b0) begin n_bad++; $display("FAIL rst_mem_cs got=%0b exp=0", bus.mem_cs); end
      n_cmp++; if ({bus.p0_rvalid, bus.p1_rvalid, bus.mem_oe} !== 3'b000) begin n_bad++; $display("FAIL rst_rvalid_oe got=%b exp=000", {bus.p0_rvalid, bus.p1_rvalid, bus.mem_oe}); end
      n_cmp++; if ({bus.p0_rdata, bus.p1_rdata} !== 64'h0) begin n_bad++; $display("FAIL rst_rdata got=%h exp=0", {bus.p0_rdata, bus.p1_rdata}); end
      n_cmp++; if ({bus.mem_W_req, bus.mem_addr, bus.mem_W_data} !== {1'b1, 64'h0}) begin n_bad++; $display("FAIL rst_mem_bus got=%b/%h/%h exp=1/0/0", bus.mem_W_req, bus.mem_addr, bus.mem_W_data); end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      n_cmp++; if ({bus.p0_gnt, bus.p1_gnt} !== 2'b00) begin n_bad++; $display("FAIL rel_cycle1_gnt got=%b exp=00", {bus.p0_gnt, bus.p1_gnt}); end
      @(negedge clk); #1;
      n_cmp++; if ({bus.p0_gnt, bus.p1_gnt} !== 2'b10) begin n_bad++; $display("FAIL rel_cycle2_gnt got=%b exp=10", {bus.p0_gnt, bus.p1_gnt}); end
      n_cmp++; if (bus.mem_cs !== 1'b1) begin n_bad++; $display("FAIL rel_cycle2_cs got=%0b exp=1", bus.mem_cs); end
      @(negedge clk);
      drive_idle();
      @(negedge clk);
   endtask

   task automatic test_write_read();
      @(negedge clk);
      bus.p0_req = 1'b1; bus.p0_we = 1'b1; bus.p0_addr = 32'd2; bus.p0_wdata = 32'hDEADBEEF;
      #1;
      n_cmp++; if (bus.p0_gnt !== 1'b1) begin n_bad++; $display("FAIL wr_p0_gnt got=%0b exp=1", bus.p0_gnt); end
      n_cmp++; if ({bus.mem_cs, bus.mem_W_req} !== 2'b10) begin n_bad++; $display("FAIL wr_cs_wreq got=%b exp=10", {bus.mem_cs, bus.mem_W_req}); end
      n_cmp++; if ({bus.mem_addr, bus.mem_W_data} !== {32'd2, 32'hDEADBEEF}) begin n_bad++; $display("FAIL wr_addr_data got=%h/%h exp=2/deadbeef", bus.mem_addr, bus.mem_W_data); end
      @(negedge clk);
      drive_idle();
      bus.p1_req = 1'b1; bus.p1_we = 1'b0; bus.p1_addr = 32'd2;
      #1;
      n_cmp++; if ({bus.p0_gnt, bus.p1_gnt} !== 2'b01) begin n_bad++; $display("FAIL rd_p1_gnt got=%b exp=01", {bus.p0_gnt, bus.p1_gnt}); end
      n_cmp++; if ({bus.p0_rvalid, bus.p1_rvalid} !== 2'b00) begin n_bad++; $display("FAIL wr_no_rsp got=%b exp=00", {bus.p0_rvalid, bus.p1_rvalid}); end
      @(negedge clk);
      drive_idle();
      #1;
      n_cmp++; if ({bus.p0_rvalid, bus.p1_rvalid} !== 2'b01) begin n_bad++; $display("FAIL rd_rvalid got=%b exp=01", {bus.p0_rvalid, bus.p1_rvalid}); end
      n_cmp++; if (bus.p1_rdata !== 32'hDEADBEEF) begin n_bad++; $display("FAIL rd_p1_rdata got=%h exp=deadbeef", bus.p1_rdata); end
      n_cmp++; if (bus.mem_oe !== 1'b1) begin n_bad++; $display("FAIL rd_mem_oe got=%0b exp=1", bus.mem_oe); end
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         bus.p0_req = 1'b1; bus.p0_we = 1'b1; bus.p0_addr = i; bus.p0_wdata = 32'h10 + i;
         #1;
         n_cmp++; if (bus.p0_gnt !== 1'b1) begin n_bad++; $display("FAIL pre_gnt[%0d] got=%0b exp=1", i, bus.p0_gnt); end
      end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (i < 4) begin
            bus.p0_req = 1'b1; bus.p0_we = 1'b0; bus.p0_addr = i;
         end else begin
            drive_idle();
         end
         #1;
         if (i < 4) begin
            n_cmp++; if (bus.p0_gnt !== 1'b1) begin n_bad++; $display("FAIL b2b_gnt[%0d] got=%0b exp=1", i, bus.p0_gnt); end
         end
         if (i > 0) begin
            n_cmp++; if (bus.p0_rvalid !== 1'b1) begin n_bad++; $display("FAIL b2b_rvalid[%0d] got=%0b exp=1", i, bus.p0_rvalid); end
            n_cmp++; if (bus.p0_rdata !== 32'h10 + i - 1) begin n_bad++; $display("FAIL b2b_rdata[%0d] got=%h exp=%h", i, bus.p0_rdata, 32'h10 + i - 1); end
         end
      end
      @(negedge clk); #1;
      n_cmp++; if (bus.p0_rvalid !== 1'b0) begin n_bad++; $display("FAIL b2b_rvalid_end got=%0b exp=0", bus.p0_rvalid); end
   endtask

   task automatic test_arbitration();
      logic [1:0] exp_g;
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 6; i++) begin
         bus.p0_req = 1'b1; bus.p0_we = 1'b0; bus.p0_addr = 32'd0;
         bus.p1_req = 1'b1; bus.p1_we = 1'b0; bus.p1_addr = 32'd1;
         #1;
`ifdef PARAM_ARB_RR_EN
         exp_g = (i % 2 == 0) ? 2'b10 : 2'b01;
`else
         exp_g = 2'b10;
`endif
         n_cmp++; if ({bus.p0_gnt, bus.p1_gnt} !== exp_g) begin n_bad++; $display("FAIL arb_gnt[%0d] got=%b exp=%b", i, {bus.p0_gnt, bus.p1_gnt}, exp_g); end
         @(negedge clk);
      end
      drive_idle();
      @(negedge clk);
   endtask

   task automatic test_out_of_range();
      @(negedge clk);
      bus.p1_req = 1'b1; bus.p1_we = 1'b0; bus.p1_addr = 32'd7;
      #1;
      n_cmp++; if (bus.p1_gnt !== 1'b1) begin n_bad++; $display("FAIL oor_rd_gnt got=%0b exp=1", bus.p1_gnt); end
      n_cmp++; if (bus.mem_cs !== 1'b0) begin n_bad++; $display("FAIL oor_rd_cs got=%0b exp=0", bus.mem_cs); end
      @(negedge clk);
      drive_idle();
      bus.p0_req = 1'b1; bus.p0_we = 1'b1; bus.p0_addr = 32'd6; bus.p0_wdata = 32'h00000BAD;
      #1;
      n_cmp++; if ({bus.p1_rvalid, bus.p1_rdata} !== {1'b1, 32'h0}) begin n_bad++; $display("FAIL oor_rd_rsp got=%0b/%h exp=1/0", bus.p1_rvalid, bus.p1_rdata); end
      n_cmp++; if (bus.mem_oe !== 1'b0) begin n_bad++; $display("FAIL oor_rd_oe got=%0b exp=0", bus.mem_oe); end
      n_cmp++; if ({bus.p0_gnt, bus.mem_cs, bus.mem_addr} !== {2'b10, 32'd6}) begin n_bad++; $display("FAIL oor_wr got=%b/%0b/%h exp=1/0/6", bus.p0_gnt, bus.mem_cs, bus.mem_addr); end
      @(negedge clk);
      drive_idle();
      bus.p0_req = 1'b1; bus.p0_we = 1'b0; bus.p0_addr = 32'd2;
      @(negedge clk);
      drive_idle();
      #1;
      n_cmp++; if (bus.p0_rdata !== 32'h12) begin n_bad++; $display("FAIL oor_wr_dropped got=%h exp=12", bus.p0_rdata); end
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      logic [1:0] exp_g;
      @(negedge clk);
      bus.p0_req = 1'b1; bus.p0_we = 1'b0; bus.p0_addr = 32'd3;
      @(negedge clk);
      drive_idle();
      #1;
      n_cmp++; if ({bus.p0_rvalid, bus.p0_rdata, bus.mem_oe} !== {1'b1, 32'h13, 1'b1}) begin n_bad++; $display("FAIL mid_pre got=%0b/%h/%0b exp=1/13/1", bus.p0_rvalid, bus.p0_rdata, bus.mem_oe); end
      #1 rst_n = 1'b0;
      #1;
      n_cmp++; if ({bus.p0_rvalid, bus.p1_rvalid, bus.mem_oe} !== 3'b000) begin n_bad++; $display("FAIL mid_rvalid_oe got=%b exp=000", {bus.p0_rvalid, bus.p1_rvalid, bus.mem_oe}); end
      n_cmp++; if (bus.p0_rdata !== 32'h0) begin n_bad++; $display("FAIL mid_rdata got=%h exp=0", bus.p0_rdata); end
      bus.p0_req = 1'b1; bus.p0_addr = 32'd0;
      bus.p1_req = 1'b1; bus.p1_addr = 32'd1;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      n_cmp++; if ({bus.p0_gnt, bus.p1_gnt} !== 2'b00) begin n_bad++; $display("FAIL mid_rel_gnt got=%b exp=00", {bus.p0_gnt, bus.p1_gnt}); end
      @(negedge clk); #1;
      n_cmp++; if ({bus.p0_gnt, bus.p1_gnt} !== 2'b10) begin n_bad++; $display("FAIL mid_first_gnt got=%b exp=10", {bus.p0_gnt, bus.p1_gnt}); end
      @(negedge clk); #1;
`ifdef PARAM_ARB_RR_EN
      exp_g = 2'b01;
`else
      exp_g = 2'b10;
`endif
      n_cmp++; if ({bus.p0_gnt, bus.p1_gnt} !== exp_g) begin n_bad++; $display("FAIL mid_second_gnt got=%b exp=%b", {bus.p0_gnt, bus.p1_gnt}, exp_g); end
      @(negedge clk);
      drive_idle();
      @(negedge clk);
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      sram_q = 32'h0;
      for (int i = 0; i < 4; i++) sram[i] = 32'h0;
      rst_n = 1'b0;
      drive_idle();
      test_reset();
      test_write_read();
      test_back_to_back();
      test_arbitration();
      test_out_of_range();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
